page_scan_scheduler: RTL and testbench
======================================

# page_scan_scheduler

Sequences the page selector of the GEFE status readback path so the VFC receives fresh status words without issuing a request per page. It sits between the serial-register page logic and the readback mux. Autonomously, it scans a contiguous page range, by default the motor status pages 16..31. Host page requests are arbitrated in with priority. Each transfer is paced on the serial register's busy flag, and the block publishes a snapshot of every word it loads.

## Interface
Parameters:
- g_first_page, 16, first page of the autonomous scan range (8 bit).
- g_last_page, 31, last page of the scan range; must be >= g_first_page.
- g_mux_latency, 2, number of clken_i pulses to wait after a page change before the mux output is valid.
- g_holdoff, 64, idle clocks between consecutive transfers.
- g_timeout, 4096, clocks allowed for tx_busy_i to rise after load_o.

Ports:
- ClkRs_ix  in  ckrs_t  carries `.clk` and `.reset`; one clock; reset is asynchronous and active-high.
- clken_i  in  1  frame clock enable; the mux registers on it.
- enable_i  in  1  enables the autonomous scan.
- host_req_i  in  1  single-cycle host page request.
- host_page_ib8  in  8  page for host_req_i.
- tx_busy_i  in  1  serial register transmit busy.
- data_ib32  in  32  readback mux output.
- page_ob8  out  8  page selection driven to the mux.
- load_o  out  1  one-clock strobe; the serial register takes data_ib32.
- host_grant_o  out  1  one-clock pulse when a host page is loaded.
- sample_valid_o  out  1  one-clock pulse with a new snapshot.
- sample_page_ob8  out  8  page of the snapshot.
- sample_ob32  out  32  snapshot data.
- timeout_o  out  1  one-clock pulse when tx_busy_i fails to rise.
- busy_o  out  1  high in every state except IDLE.

## Operation
- The FSM has five states: IDLE, SELECT, LOAD, WAIT_TX and HOLDOFF.
- Host pending flag:
  - host_req_i sets pending and latches host_page_ib8.
  - A new request while pending overwrites the latched page (last wins).
- IDLE:
  - If pending, drive the host page, clear pending and go to SELECT with source=HOST.
  - Else if enable_i, drive scan_ptr and go to SELECT with source=SCAN.
  - Host always wins a simultaneous tie.
- SELECT: count g_mux_latency clken_i pulses, then go to LOAD.
- LOAD (one clock):
  - Assert load_o.
  - Capture data_ib32 and page_ob8 into the sample outputs and pulse sample_valid_o.
  - If source=HOST, pulse host_grant_o.
  - Go to WAIT_TX.
- WAIT_TX:
  - Wait for tx_busy_i to rise, then to fall, then go to HOLDOFF.
  - If tx_busy_i does not rise within g_timeout clocks, pulse timeout_o and go to HOLDOFF.
  - The falling phase has no timeout.
- HOLDOFF:
  - Count g_holdoff clocks, then go to IDLE.
  - On exit, if source=SCAN, advance scan_ptr; it wraps from g_last_page to g_first_page.
  - A host transfer never advances scan_ptr.
- page_ob8 holds its value in every state until the next selection, so the mux keeps the last page.
- enable_i falling mid-transfer: the current transfer completes, then the FSM stays in IDLE.
- g_first_page == g_last_page: every scan transfer uses the same page.
- Counters are saturating-free:
  - The holdoff counter has width $clog2(g_holdoff+1).
  - The timeout counter has width $clog2(g_timeout+1).

## Timing
- Reset values:
  - State IDLE; page_ob8 = 0 (loopback page); scan_ptr = g_first_page.
  - All pulse outputs 0; sample_ob32 = 0; sample_page_ob8 = 0; busy_o = 0; pending cleared.
- Reset asserted mid-transfer returns everything to reset values immediately, without waiting for a clock edge.
- host_req_i at edge n while IDLE: page_ob8 is updated and busy_o = 1 from edge n+1.
- load_o fires on the clock after the g_mux_latency-th clken_i pulse seen in SELECT.
- sample_* and host_grant_o are coincident with load_o.
- All outputs are registered.

## Structure
- Add the state enum t_pss_state to MCPkg.
- Add the default scan-range constants PSS_FIRST_PAGE and PSS_LAST_PAGE to constants, next to the other GEFE constants.
- Reuse the existing get_edge for tx_busy_i rising and falling detection; no new sub-module.
- Add an elaboration-time assertion that g_first_page <= g_last_page.

## Test plan
- Scan wrap: enable_i=1, g_first_page=16, g_last_page=18, tx_busy_i pulsed 10 clocks after each load → pages 16, 17, 18, 16 on successive load_o pulses.
- Host priority: host_req_i with page 3 on the same edge enable_i rises → first load_o has page 3 with host_grant_o=1; the next load is page 16.
- Host overwrite: requests for pages 1 then 2 during WAIT_TX → exactly one host transfer, page 2; scan_ptr is unchanged.
- Timeout: tx_busy_i held 0 → timeout_o pulses exactly g_timeout clocks after load_o; the scan continues with the next page after g_holdoff.
- Mux latency: clken_i every 3rd clock with g_mux_latency=2 → load_o follows the second clken_i pulse after the page change; sample_ob32 equals the mux value for the new page.
- Async reset: reset asserted in WAIT_TX → page_ob8=0 and busy_o=0 immediately; after release, the first load_o uses page g_first_page.

Source files
------------

// File: rtl/page_scan_scheduler_pkg.sv
// Shared types and constants for the GEFE status page scan scheduler.
// Holds the clock/reset bundle, FSM state enum and default scan range.
package page_scan_scheduler_pkg;

  typedef struct packed {
    logic clk;
    logic reset;
  } ckrs_t;

  typedef enum logic [2:0] {
    PSS_IDLE,
    PSS_SELECT,
    PSS_LOAD,
    PSS_WAIT_TX,
    PSS_HOLDOFF
  } t_pss_state;

  typedef enum logic {
    SRC_SCAN,
    SRC_HOST
  } t_pss_src;

  localparam logic [7:0] PSS_FIRST_PAGE = 8'd16;
  localparam logic [7:0] PSS_LAST_PAGE  = 8'd31;

  function automatic logic [7:0] pss_next_page(
    input logic [7:0] ptr,
    input logic [7:0] first,
    input logic [7:0] last
  );
    return (ptr >= last) ? first : ptr + 8'd1;
  endfunction

endpackage

// File: rtl/page_scan_scheduler_get_edge.sv
// Rising/falling edge detector for a signal already in the clk domain.
// Ports: clk, rst, sig in; rise, fall are one-clock combinational flags.
module page_scan_scheduler_get_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/page_scan_scheduler.sv
// Page selector sequencer: scans a page range, arbitrates host requests,
// paces loads on tx_busy_i and publishes a snapshot of each loaded word.
// Ports: ClkRs_ix (clk/reset), clken_i, enable_i, host_req_i,
// host_page_ib8, tx_busy_i, data_ib32 in; page_ob8, load_o,
// host_grant_o, sample_valid_o, sample_page_ob8, sample_ob32,
// timeout_o, busy_o out (all registered).
module page_scan_scheduler
  import page_scan_scheduler_pkg::*;
#(
  parameter logic [7:0] g_first_page  = PSS_FIRST_PAGE,
  parameter logic [7:0] g_last_page   = PSS_LAST_PAGE,
  parameter int         g_mux_latency = 2,
  parameter int         g_holdoff     = 64,
  parameter int         g_timeout     = 4096
) (
  input  ckrs_t        ClkRs_ix,
  input  logic         clken_i,
  input  logic         enable_i,
  input  logic         host_req_i,
  input  logic [7:0]   host_page_ib8,
  input  logic         tx_busy_i,
  input  logic [31:0]  data_ib32,
  output logic [7:0]   page_ob8,
  output logic         load_o,
  output logic         host_grant_o,
  output logic         sample_valid_o,
  output logic [7:0]   sample_page_ob8,
  output logic [31:0]  sample_ob32,
  output logic         timeout_o,
  output logic         busy_o
);

  localparam int MW = $clog2(g_mux_latency + 1);
  localparam int HW = $clog2(g_holdoff + 1);
  localparam int TW = $clog2(g_timeout + 1);

  localparam logic [MW-1:0] M_LAST = MW'(g_mux_latency - 1);
  localparam logic [HW-1:0] H_LAST = HW'(g_holdoff - 1);
  localparam logic [TW-1:0] T_LAST = TW'(g_timeout - 1);

  if (g_first_page > g_last_page) begin : g_bad_range
    $error("page_scan_scheduler: g_first_page > g_last_page");
  end

  if (g_mux_latency < 1 || g_holdoff < 1 || g_timeout < 1)
  begin : g_bad_count
    $error("page_scan_scheduler: counts must be >= 1");
  end

  logic clk;
  logic rst;

  assign clk = ClkRs_ix.clk;
  assign rst = ClkRs_ix.reset;

  t_pss_state    state;
  t_pss_src      src;
  logic [7:0]    scan_ptr;
  logic          pending;
  logic [7:0]    host_page;
  logic [MW-1:0] mcnt;
  logic [HW-1:0] hcnt;
  logic [TW-1:0] tcnt;
  logic          risen;
  logic          busy_rise;
  logic          busy_fall;

  page_scan_scheduler_get_edge u_busy_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (tx_busy_i),
    .rise (busy_rise),
    .fall (busy_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= PSS_IDLE;
      src             <= SRC_SCAN;
      page_ob8        <= 8'd0;
      scan_ptr        <= g_first_page;
      pending         <= 1'b0;
      host_page       <= 8'd0;
      mcnt            <= '0;
      hcnt            <= '0;
      tcnt            <= '0;
      risen           <= 1'b0;
      load_o          <= 1'b0;
      host_grant_o    <= 1'b0;
      sample_valid_o  <= 1'b0;
      sample_page_ob8 <= 8'd0;
      sample_ob32     <= 32'd0;
      timeout_o       <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      load_o         <= 1'b0;
      host_grant_o   <= 1'b0;
      sample_valid_o <= 1'b0;
      timeout_o      <= 1'b0;

      // Last request wins; IDLE below clears it when consumed.
      if (host_req_i) begin
        pending   <= 1'b1;
        host_page <= host_page_ib8;
      end

      unique case (state)
        PSS_IDLE: begin
          mcnt <= '0;
          // A request on this very edge is served without delay.
          if (pending || host_req_i) begin
            page_ob8 <= host_req_i ? host_page_ib8 : host_page;
            pending  <= 1'b0;
            src      <= SRC_HOST;
            busy_o   <= 1'b1;
            state    <= PSS_SELECT;
          end else if (enable_i) begin
            page_ob8 <= scan_ptr;
            src      <= SRC_SCAN;
            busy_o   <= 1'b1;
            state    <= PSS_SELECT;
          end
        end

        PSS_SELECT: begin
          if (clken_i) begin
            if (mcnt == M_LAST) state <= PSS_LOAD;
            else                mcnt  <= mcnt + 1'b1;
          end
        end

        PSS_LOAD: begin
          load_o          <= 1'b1;
          sample_valid_o  <= 1'b1;
          sample_ob32     <= data_ib32;
          sample_page_ob8 <= page_ob8;
          host_grant_o    <= (src == SRC_HOST);
          tcnt            <= '0;
          risen           <= 1'b0;
          state           <= PSS_WAIT_TX;
        end

        PSS_WAIT_TX: begin
          if (!risen) begin
            if (busy_rise) begin
              risen <= 1'b1;
            end else if (tcnt == T_LAST) begin
              timeout_o <= 1'b1;
              hcnt      <= '0;
              state     <= PSS_HOLDOFF;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end else if (busy_fall) begin
            hcnt  <= '0;
            state <= PSS_HOLDOFF;
          end
        end

        PSS_HOLDOFF: begin
          if (hcnt == H_LAST) begin
            busy_o <= 1'b0;
            state  <= PSS_IDLE;
            if (src == SRC_SCAN)
              scan_ptr <= pss_next_page(
                scan_ptr, g_first_page, g_last_page);
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end

        default: state <= PSS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_page_scan_scheduler.sv
// Directed scoreboard bench for page_scan_scheduler with a mux model
// and a serial-register model that pulses tx_busy_i after each load.
module tb_page_scan_scheduler;
  import page_scan_scheduler_pkg::*;

  localparam int TOUT = 40;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  ckrs_t       ckrs;
  logic        clken = 1'b0;
  logic        enable = 1'b0;
  logic        host_req = 1'b0;
  logic [7:0]  host_page = 8'd0;
  logic        tx_busy;
  logic [31:0] mux_q;
  logic [7:0]  page;
  logic        load;
  logic        grant;
  logic        svalid;
  logic [7:0]  spage;
  logic [31:0] sdata;
  logic        tout;
  logic        busy;

  assign ckrs.clk   = clk;
  assign ckrs.reset = rst;

  always #5 clk = ~clk;

  page_scan_scheduler #(
    .g_first_page  (8'd16),
    .g_last_page   (8'd18),
    .g_mux_latency (2),
    .g_holdoff     (HOLD),
    .g_timeout     (TOUT)
  ) dut (
    .ClkRs_ix        (ckrs),
    .clken_i         (clken),
    .enable_i        (enable),
    .host_req_i      (host_req),
    .host_page_ib8   (host_page),
    .tx_busy_i       (tx_busy),
    .data_ib32       (mux_q),
    .page_ob8        (page),
    .load_o          (load),
    .host_grant_o    (grant),
    .sample_valid_o  (svalid),
    .sample_page_ob8 (spage),
    .sample_ob32     (sdata),
    .timeout_o       (tout),
    .busy_o          (busy)
  );

  function automatic logic [31:0] mux_word(input logic [7:0] p);
    return {8'hA5, p, ~p, 8'h3C};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)        mux_q <= 32'd0;
    else if (clken) mux_q <= mux_word(page);
  end

  // Serial register: busy rises 10 clocks after load, lasts 3 clocks.
  logic tx_mute = 1'b0;
  int   dly;
  int   bcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dly  <= 0;
      bcnt <= 0;
    end else begin
      if (load && !tx_mute) dly <= 10;
      else if (dly > 0)     dly <= dly - 1;
      if (dly == 1)         bcnt <= 3;
      else if (bcnt > 0)    bcnt <= bcnt - 1;
    end
  end

  assign tx_busy = (bcnt != 0);

  // clken every 3rd clock; count pulses seen since the last page change.
  int         div = 0;
  int         pulses = 0;
  bit         ck1 = 1'b0;
  bit         ck2 = 1'b0;
  logic [7:0] last_pg = 8'd0;
  int         nloads = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ck2 = ck1;
    ck1 = clken;
    if (page !== last_pg) pulses = 0;
    else                  pulses = pulses + int'(ck1);
    last_pg = page;
    if (load === 1'b1) nloads = nloads + 1;
    div   = (div == 2) ? 0 : div + 1;
    clken = (div == 0);
  end

  typedef struct {
    logic [7:0] pg;
    logic       host;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   load_cyc = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expired(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic push(input logic [7:0] p, input logic h);
    exp_t e;
    e.pg   = p;
    e.host = h;
    sb.push_back(e);
  endtask

  task automatic expect_load(input string tag);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (load === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      expired(tag);
    end else if (sb.size() == 0) begin
      expired({tag, "_empty_sb"});
    end else begin
      e        = sb.pop_front();
      load_cyc = cyc;
      check({tag, "_page"},  32'(page),   32'(e.pg));
      check({tag, "_spage"}, 32'(spage),  32'(e.pg));
      check({tag, "_grant"}, 32'(grant),  32'(e.host));
      check({tag, "_svld"},  32'(svalid), 32'd1);
      check({tag, "_data"},  sdata,       mux_word(e.pg));
      check({tag, "_lat"},
            32'((pulses - int'(ck1) == 2) && ck2), 32'd1);
    end
  endtask

  initial begin
    int t0;
    bit seen;

    repeat (3) @(negedge clk);
    #1;
    check("rst_page",  32'(page),   32'd0);
    check("rst_busy",  32'(busy),   32'd0);
    check("rst_load",  32'(load),   32'd0);
    check("rst_svld",  32'(svalid), 32'd0);
    check("rst_spage", 32'(spage),  32'd0);
    check("rst_sdata", sdata,       32'd0);
    check("rst_grant", 32'(grant),  32'd0);
    check("rst_tout",  32'(tout),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Host request and enable on the same edge: host wins.
    host_req  = 1'b1;
    host_page = 8'd3;
    enable    = 1'b1;
    @(posedge clk);
    #1;
    check("host_page_n1", 32'(page), 32'd3);
    check("host_busy_n1", 32'(busy), 32'd1);
    @(negedge clk);
    host_req = 1'b0;
    push(8'd3, 1'b1);
    push(8'd16, 1'b0);
    push(8'd17, 1'b0);
    push(8'd18, 1'b0);
    push(8'd16, 1'b0);
    expect_load("prio_host");
    expect_load("scan16");
    expect_load("scan17");
    expect_load("scan18");
    expect_load("wrap16");

    // Two host requests during WAIT_TX: only the last one is served.
    @(negedge clk);
    host_req  = 1'b1;
    host_page = 8'd1;
    @(negedge clk);
    host_req = 1'b0;
    @(negedge clk);
    host_req  = 1'b1;
    host_page = 8'd2;
    @(negedge clk);
    host_req = 1'b0;
    push(8'd2, 1'b1);
    push(8'd17, 1'b0);
    expect_load("ovr_host2");
    expect_load("ovr_scan17");

    // Mute the serial register for this transfer.
    tx_mute = 1'b1;
    t0   = load_cyc;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (tout === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      expired("tout_wait");
    end else begin
      check("tout_delay", 32'(cyc - t0), 32'(TOUT));
      @(negedge clk);
      #1;
      check("tout_pulse", 32'(tout), 32'd0);
    end
    tx_mute = 1'b0;
    push(8'd18, 1'b0);
    expect_load("after_tout18");

    // Asynchronous reset while waiting for tx_busy_i.
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_page",  32'(page),  32'd0);
    check("arst_busy",  32'(busy),  32'd0);
    check("arst_sdata", sdata,      32'd0);
    check("arst_spage", 32'(spage), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    push(8'd16, 1'b0);
    expect_load("arst_first");

    // Drop enable mid-transfer: finish, then stay idle.
    enable = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (busy === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) expired("dis_idle");
    t0 = nloads;
    repeat (60) @(negedge clk);
    #1;
    check("dis_noload", 32'(nloads), 32'(t0));
    check("dis_busy",   32'(busy),   32'd0);
    check("sb_empty",   32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
